// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-style controller: state codes,
// opcodes, datapath select codes and small decode helpers.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_J     = 4'b0010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FETCH doubles as the "unrecognised opcode" result.
    function automatic state_t decode_target(input logic [3:0] opcode);
        state_t target;
        case (opcode)
            OP_RTYPE:     target = RTEX;
            OP_ADDI:      target = ADDIEX;
            OP_LW, OP_SW: target = MEMADR;
            OP_BEQ:       target = BRANCH;
            OP_J:         target = JUMP;
            default:      target = FETCH;
        endcase
        return target;
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait counter; expired flags that one more missed cycle reaches TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with memory-wait timeout and illegal-opcode detect.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    state_t state_q;
    state_t next_state;
    logic   regdst_q;
    logic   ready;
    logic   wait_clr;
    logic   wait_inc;
    logic   wait_expired;

    // Outputs decode straight from state_q, so reset must also mask mem_ready.
    assign ready = mem_ready & reset_n;
    assign state = state_q;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .expired(wait_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            regdst_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == RTEX) begin
                regdst_q <= 1'b1;
            end else if (state_q == ADDIEX) begin
                regdst_q <= 1'b0;
            end
        end
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUSRCB_REG;
        aluop      = ALUOP_ADD;
        pcsrc      = PCSRC_ALU;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        wait_inc   = 1'b0;
        next_state = state_q;

        case (state_q)
            FETCH: begin
                memread  = 1'b1;
                alusrcb  = ALUSRCB_FOUR;
                irwrite  = ready;
                pcwrite  = ready;
                wait_inc = ~ready;
                if (ready) begin
                    next_state = DECODE;
                end else if (wait_expired) begin
                    bus_err    = 1'b1;
                    next_state = FETCH;
                end
            end
            DECODE: begin
                alusrcb    = ALUSRCB_BRANCH;
                next_state = decode_target(op);
                illegal    = (next_state == FETCH);
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = ALUSRCB_IMM;
                next_state = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread  = 1'b1;
                iord     = 1'b1;
                wait_inc = ~ready;
                if (ready) begin
                    next_state = MEMWB;
                end else if (wait_expired) begin
                    bus_err    = 1'b1;
                    next_state = FETCH;
                end
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                wait_inc = ~ready;
                if (ready || wait_expired) begin
                    bus_err    = ~ready;
                    next_state = FETCH;
                end
            end
            RTEX: begin
                alusrca    = 1'b1;
                alusrcb    = ALUSRCB_REG;
                aluop      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = ALUSRCB_IMM;
                next_state = ALUWB;
            end
            ALUWB: begin
                regwrite   = 1'b1;
                regdst     = regdst_q;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_TARGET;
                pcwrite    = zero;
                next_state = FETCH;
            end
            JUMP: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                next_state = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        // A timeout re-enters FETCH from FETCH, which still counts as a fresh entry.
        wait_clr = is_wait_state(next_state) && ((next_state != state_q) || bus_err);
    end

endmodule
